// File: rtl/regfile_write_arbiter_if.sv
// Write-port bundle for regfile_write_arbiter: per-requester valid/ready/addr/data
// and the registered register-file write port plus status.
interface regfile_write_arbiter_if #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [NUM_REQ-1:0]            reqValid;
  logic [NUM_REQ*ADDR_WIDTH-1:0] reqAddr;
  logic [NUM_REQ*DATA_WIDTH-1:0] reqData;
  logic [NUM_REQ-1:0]            reqReady;
  logic [ADDR_WIDTH-1:0]         writeAddress;
  logic [DATA_WIDTH-1:0]         writeData;
  logic                          writeEnable;
  logic [NUM_REQ-1:0]            pendingMask;
  logic [2:0]                    grantId;

  modport master (
    output reqValid, reqAddr, reqData,
    input  reqReady, writeAddress, writeData, writeEnable, pendingMask, grantId
  );

  modport slave (
    input  reqValid, reqAddr, reqData,
    output reqReady, writeAddress, writeData, writeEnable, pendingMask, grantId
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing one register-file write port among NUM_REQ one-entry
// writeback buffers. Optional macro ZERO_REG_GUARD_EN suppresses writes to register 0.
module regfile_write_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                clk,
  input  logic                reset,
  regfile_write_arbiter_if.slave bus
);

  logic [NUM_REQ-1:0]    pending;
  logic [NUM_REQ-1:0]    grant;
  logic [NUM_REQ-1:0]    reqReady;
  logic [ADDR_WIDTH-1:0] addrBuf [NUM_REQ];
  logic [DATA_WIDTH-1:0] dataBuf [NUM_REQ];
  logic [2:0]            pointer;
  logic [2:0]            grantIdx;
  logic [2:0]            nextPointer;
  logic                  found;
  logic [ADDR_WIDTH-1:0] selAddr;
  logic [DATA_WIDTH-1:0] selData;

  logic [ADDR_WIDTH-1:0] writeAddressQ;
  logic [DATA_WIDTH-1:0] writeDataQ;
  logic                  writeEnableQ;
  logic [2:0]            grantIdQ;

  // Two-pass search: indices at/after the pointer first, then wrap from 0.
  always_comb begin
    found    = 1'b0;
    grantIdx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found && pending[i] && (i >= 32'(pointer))) begin
        found    = 1'b1;
        grantIdx = 3'(i);
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found && pending[i]) begin
        found    = 1'b1;
        grantIdx = 3'(i);
      end
    end

    grant   = '0;
    selAddr = '0;
    selData = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (found && (grantIdx == 3'(i))) begin
        grant[i] = 1'b1;
        selAddr  = addrBuf[i];
        selData  = dataBuf[i];
      end
    end

    nextPointer = (32'(grantIdx) == NUM_REQ - 1) ? '0 : grantIdx + 3'd1;
  end

  assign reqReady = ~pending | grant;

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (bus.reqValid[i] && reqReady[i]) begin
        addrBuf[i] <= bus.reqAddr[i*ADDR_WIDTH +: ADDR_WIDTH];
        dataBuf[i] <= bus.reqData[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending       <= '0;
      pointer       <= '0;
      writeEnableQ  <= 1'b0;
      writeAddressQ <= '0;
      writeDataQ    <= '0;
      grantIdQ      <= '0;
    end else begin
      // A reload in the same cycle as the drain keeps the buffer occupied.
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (bus.reqValid[i] && reqReady[i]) begin
          pending[i] <= 1'b1;
        end else if (grant[i]) begin
          pending[i] <= 1'b0;
        end
      end

      if (found) begin
        pointer       <= nextPointer;
        writeAddressQ <= selAddr;
        writeDataQ    <= selData;
        grantIdQ      <= grantIdx;
`ifdef ZERO_REG_GUARD_EN
        writeEnableQ  <= (selAddr != '0);
`else
        writeEnableQ  <= 1'b1;
`endif
      end else begin
        writeEnableQ  <= 1'b0;
      end
    end
  end

  assign bus.reqReady     = reqReady;
  assign bus.pendingMask  = pending;
  assign bus.writeEnable  = writeEnableQ;
  assign bus.writeAddress = writeAddressQ;
  assign bus.writeData    = writeDataQ;
  assign bus.grantId      = grantIdQ;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed cycle-by-cycle vector bench for regfile_write_arbiter with a small
// register-file model fed from the write port.
module tb_regfile_write_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;

`ifdef ZERO_REG_GUARD_EN
  localparam logic ZW = 1'b0;
`else
  localparam logic ZW = 1'b1;
`endif

  logic clk;
  logic reset;

  regfile_write_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  regfile_write_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] rf [32] = '{default: '0};
  always @(posedge clk) begin
    if (bus.writeEnable) rf[bus.writeAddress] <= bus.writeData;
  end

  typedef struct {
    logic        rst;
    logic [3:0]  valid;
    logic [19:0] addr;
    logic [127:0] data;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [2:0]  gid;
    logic [3:0]  pend;
    logic [3:0]  rdy;
  } vec_t;

  vec_t vecs[$];
  int nCompared = 0;
  int nMismatched = 0;

  function automatic logic [19:0] A(input logic [4:0] a3, a2, a1, a0);
    return {a3, a2, a1, a0};
  endfunction

  function automatic logic [127:0] D(input logic [31:0] d3, d2, d1, d0);
    return {d3, d2, d1, d0};
  endfunction

  task automatic addv(input logic rst, input logic [3:0] valid, input logic [19:0] a,
                      input logic [127:0] d, input logic we, input logic [4:0] wa,
                      input logic [31:0] wd, input logic [2:0] gid,
                      input logic [3:0] pend, input logic [3:0] rdy);
    vec_t v;
    v.rst = rst; v.valid = valid; v.addr = a; v.data = d;
    v.we = we; v.wa = wa; v.wd = wd; v.gid = gid; v.pend = pend; v.rdy = rdy;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    reset        = 1'b1;
    bus.reqValid = '0;
    bus.reqAddr  = '0;
    bus.reqData  = '0;

    // reset held with all requesters valid
    addv(1, 4'b1111, A(0,0,0,0), D(0,0,0,0), 0, 0, 0, 0, 4'b0000, 4'b1111);
    addv(1, 4'b1111, A(0,0,0,0), D(0,0,0,0), 0, 0, 0, 0, 4'b0000, 4'b1111);
    addv(0, 4'b0000, A(0,0,0,0), D(0,0,0,0), 0, 0, 0, 0, 4'b0000, 4'b1111);
    // single writes from req0, second accepted while first drains
    addv(0, 4'b0001, A(0,0,0,16), D(0,0,0,1), 0, 0, 0, 0, 4'b0001, 4'b1111);
    addv(0, 4'b0001, A(0,0,0,17), D(0,0,0,3), 1, 16, 1, 0, 4'b0001, 4'b1111);
    addv(0, 4'b0000, A(0,0,0,0), D(0,0,0,0), 1, 17, 3, 0, 4'b0000, 4'b1111);
    addv(0, 4'b0000, A(0,0,0,0), D(0,0,0,0), 0, 17, 3, 0, 4'b0000, 4'b1111);
    // reset pointer, then round-robin batch
    addv(1, 4'b0000, A(0,0,0,0), D(0,0,0,0), 0, 0, 0, 0, 4'b0000, 4'b1111);
    addv(0, 4'b1111, A(7,6,5,4), D(13,12,11,10), 0, 0, 0, 0, 4'b1111, 4'b0001);
    addv(0, 4'b0000, A(0,0,0,0), D(0,0,0,0), 1, 4, 10, 0, 4'b1110, 4'b0011);
    addv(0, 4'b0000, A(0,0,0,0), D(0,0,0,0), 1, 5, 11, 1, 4'b1100, 4'b0111);
    addv(0, 4'b0000, A(0,0,0,0), D(0,0,0,0), 1, 6, 12, 2, 4'b1000, 4'b1111);
    addv(0, 4'b0000, A(0,0,0,0), D(0,0,0,0), 1, 7, 13, 3, 4'b0000, 4'b1111);
    addv(0, 4'b0000, A(0,0,0,0), D(0,0,0,0), 0, 7, 13, 3, 4'b0000, 4'b1111);
    // pointer wrapped to 0: req0 before req3
    addv(0, 4'b1001, A(9,0,0,8), D(21,0,0,20), 0, 7, 13, 3, 4'b1001, 4'b0111);
    addv(0, 4'b0000, A(0,0,0,0), D(0,0,0,0), 1, 8, 20, 0, 4'b1000, 4'b1111);
    addv(0, 4'b0000, A(0,0,0,0), D(0,0,0,0), 1, 9, 21, 3, 4'b0000, 4'b1111);
    addv(0, 4'b0000, A(0,0,0,0), D(0,0,0,0), 0, 9, 21, 3, 4'b0000, 4'b1111);
    // back-to-back on req2
    addv(0, 4'b0100, A(0,2,0,0), D(0,5,0,0), 0, 9, 21, 3, 4'b0100, 4'b1111);
    addv(0, 4'b0100, A(0,2,0,0), D(0,6,0,0), 1, 2, 5, 2, 4'b0100, 4'b1111);
    addv(0, 4'b0100, A(0,2,0,0), D(0,7,0,0), 1, 2, 6, 2, 4'b0100, 4'b1111);
    addv(0, 4'b0100, A(0,2,0,0), D(0,8,0,0), 1, 2, 7, 2, 4'b0100, 4'b1111);
    addv(0, 4'b0000, A(0,0,0,0), D(0,0,0,0), 1, 2, 8, 2, 4'b0000, 4'b1111);
    addv(0, 4'b0000, A(0,0,0,0), D(0,0,0,0), 0, 2, 8, 2, 4'b0000, 4'b1111);
    // move pointer to 2, then collision on addr 20
    addv(0, 4'b0010, A(0,0,1,0), D(0,0,32'h55,0), 0, 2, 8, 2, 4'b0010, 4'b1111);
    addv(0, 4'b0000, A(0,0,0,0), D(0,0,0,0), 1, 1, 32'h55, 1, 4'b0000, 4'b1111);
    addv(0, 4'b1010, A(20,0,20,0), D(32'hBB,0,32'hAA,0), 0, 1, 32'h55, 1, 4'b1010, 4'b1101);
    addv(0, 4'b0000, A(0,0,0,0), D(0,0,0,0), 1, 20, 32'hBB, 3, 4'b0010, 4'b1111);
    addv(0, 4'b0000, A(0,0,0,0), D(0,0,0,0), 1, 20, 32'hAA, 1, 4'b0000, 4'b1111);
    addv(0, 4'b0000, A(0,0,0,0), D(0,0,0,0), 0, 20, 32'hAA, 1, 4'b0000, 4'b1111);
    // address 0 entry
    addv(0, 4'b0001, A(0,0,0,0), D(0,0,0,9), 0, 20, 32'hAA, 1, 4'b0001, 4'b1111);
    addv(0, 4'b0000, A(0,0,0,0), D(0,0,0,0), ZW, 0, 9, 0, 4'b0000, 4'b1111);
    addv(0, 4'b0000, A(0,0,0,0), D(0,0,0,0), 0, 0, 9, 0, 4'b0000, 4'b1111);
    // three pending, then reset discards them
    addv(0, 4'b0111, A(0,12,11,10), D(0,102,101,100), 0, 0, 9, 0, 4'b0111, 4'b1010);
    addv(1, 4'b0000, A(0,0,0,0), D(0,0,0,0), 0, 0, 0, 0, 4'b0000, 4'b1111);
    addv(0, 4'b0000, A(0,0,0,0), D(0,0,0,0), 0, 0, 0, 0, 4'b0000, 4'b1111);
    addv(0, 4'b0000, A(0,0,0,0), D(0,0,0,0), 0, 0, 0, 0, 4'b0000, 4'b1111);

    foreach (vecs[i]) begin
      reset        = vecs[i].rst;
      bus.reqValid = vecs[i].valid;
      bus.reqAddr  = vecs[i].addr;
      bus.reqData  = vecs[i].data;
      @(posedge clk);
      #1;
      check("writeEnable", i, 32'(bus.writeEnable), 32'(vecs[i].we));
      check("writeAddress", i, 32'(bus.writeAddress), 32'(vecs[i].wa));
      check("writeData", i, bus.writeData, vecs[i].wd);
      check("grantId", i, 32'(bus.grantId), 32'(vecs[i].gid));
      check("pendingMask", i, 32'(bus.pendingMask), 32'(vecs[i].pend));
      check("reqReady", i, 32'(bus.reqReady), 32'(vecs[i].rdy));
    end

    // Sustained contention: all four held valid, grants must rotate every cycle.
    bus.reqValid = 4'b1111;
    bus.reqAddr  = A(27, 26, 25, 24);
    bus.reqData  = D(32'h103, 32'h102, 32'h101, 32'h100);
    @(posedge clk); #1;
    check("contendLoad", 0, 32'(bus.pendingMask), 32'hF);
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      check("contendWe", k, 32'(bus.writeEnable), 32'd1);
      check("contendGid", k, 32'(bus.grantId), 32'(k % 4));
      check("contendAddr", k, 32'(bus.writeAddress), 32'(24 + k % 4));
    end
    bus.reqValid = '0;
    n = 0;
    while (bus.pendingMask != '0 && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check("drainCycles", 0, 32'(n), 32'd4);

    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rf16", 0, rf[16], 32'd1);
    check("rf17", 0, rf[17], 32'd3);
    check("rf4", 0, rf[4], 32'd10);
    check("rf7", 0, rf[7], 32'd13);
    check("rf2", 0, rf[2], 32'd8);
    check("rf20", 0, rf[20], 32'hAA);
    check("rf10", 0, rf[10], 32'd0);
    check("rf12", 0, rf[12], 32'd0);
    check("rf26", 0, rf[26], 32'h102);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
